// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stall, branch flush, memory-wait freeze,
// plus a saturating stall-cycle counter and a sticky memory-timeout flag.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter logic [31:0] NOP         = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic [31:0] ex_instr,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_enable,
  output logic        ifid_enable,
  output logic        idex_enable,
  output logic        exmem_enable,
  output logic        memwb_enable,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [31:0] stall_cycles,
  output logic        mem_error
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  typedef enum logic {
    S_RUN,
    S_MEM_WAIT
  } state_t;

  state_t              r_state;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_mem_err;
  logic [31:0]         r_stall;

  logic [6:0] w_id_op;
  logic [4:0] w_id_rs1;
  logic [4:0] w_id_rs2;
  logic [6:0] w_ex_op;
  logic [4:0] w_ex_rd;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic       w_load_use;
  logic       w_freeze;
  logic       w_unused;

  assign w_id_op  = id_instr[6:0];
  assign w_id_rs1 = id_instr[19:15];
  assign w_id_rs2 = id_instr[24:20];
  assign w_ex_op  = ex_instr[6:0];
  assign w_ex_rd  = ex_instr[11:7];

  // Fields that play no part in hazard detection.
  assign w_unused = ^{id_instr[31:25], id_instr[14:7], ex_instr[31:12], NOP};

  assign w_rs1_used = !((w_id_op == OP_LUI) || (w_id_op == OP_AUIPC) || (w_id_op == OP_JAL));
  assign w_rs2_used = (w_id_op == OP_BRANCH) || (w_id_op == OP_STORE) || (w_id_op == OP_OP);

  assign w_load_use = (w_ex_op == OP_LOAD) && (w_ex_rd != 5'd0) &&
                      ((w_rs1_used && (w_id_rs1 == w_ex_rd)) ||
                       (w_rs2_used && (w_id_rs2 == w_ex_rd)));

  // The ready cycle itself never freezes, in either state.
  assign w_freeze = !mem_ready && (mem_req || (r_state == S_MEM_WAIT));

  always_comb begin
    pc_enable    = 1'b1;
    ifid_enable  = 1'b1;
    idex_enable  = 1'b1;
    exmem_enable = 1'b1;
    memwb_enable = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_freeze) begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      memwb_enable = 1'b0;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
      r_stall    <= '0;
    end else begin
      if (!pc_enable && (r_stall != 32'hFFFFFFFF)) begin
        r_stall <= r_stall + 32'd1;
      end
      case (r_state)
        S_RUN: begin
          r_wait_cnt <= '0;
          if (mem_req && !mem_ready) begin
            r_state <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt < WCNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            if ((r_wait_cnt + WCNT_W'(1)) == WCNT_MAX) begin
              r_mem_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign stall_cycles = r_stall;
  assign mem_error    = r_mem_err;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_hazard_unit;

  localparam int unsigned TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic [31:0] id_instr;
  logic [31:0] ex_instr;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
  logic        ifid_flush, idex_flush;
  logic [31:0] stall_cycles;
  logic        mem_error;

  hazard_unit #(.MEM_TIMEOUT(TIMEOUT), .NOP(32'h00000013)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_instr     (id_instr),
    .ex_instr     (ex_instr),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_enable    (pc_enable),
    .ifid_enable  (ifid_enable),
    .idex_enable  (idex_enable),
    .exmem_enable (exmem_enable),
    .memwb_enable (memwb_enable),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .stall_cycles (stall_cycles),
    .mem_error    (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_NOP    = 32'h00000013;
  localparam logic [31:0] I_LW_X5  = 32'h0000A283;
  localparam logic [31:0] I_LW_X0  = 32'h0000A003;
  localparam logic [31:0] I_ADD    = 32'h00228333;
  localparam logic [31:0] I_LUI_X5 = 32'h000012B7;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  bit          m_waiting;
  int          m_wait_len;
  bit          m_err;
  logic [31:0] m_stall;

  // Sampled DUT values: comb outputs during the cycle, registers after the edge.
  logic [6:0]  s_vec;
  logic [31:0] a_stall;
  logic        a_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_load_use(input logic [31:0] id, input logic [31:0] ex);
    logic [6:0] iop;
    logic [6:0] eop;
    bit uses1, uses2;
    int rd, r1, r2;
    iop = id[6:0];
    eop = ex[6:0];
    rd  = int'(ex[11:7]);
    r1  = int'(id[19:15]);
    r2  = int'(id[24:20]);
    uses1 = !(iop inside {7'h37, 7'h17, 7'h6F});
    uses2 = iop inside {7'h63, 7'h23, 7'h33};
    if (eop != 7'h03 || rd == 0) return 1'b0;
    return (uses1 && r1 == rd) || (uses2 && r2 == rd);
  endfunction

  // Outputs ordered {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}.
  function automatic logic [6:0] model_outs(input bit r, input logic [31:0] id,
                                            input logic [31:0] ex, input bit br,
                                            input bit req, input bit rdy);
    if (r) return 7'b1111111;
    if (!rdy && (req || m_waiting)) return 7'b0000000;
    if (br) return 7'b1111111;
    if (model_load_use(id, ex)) return 7'b0011101;
    return 7'b1111100;
  endfunction

  task automatic step(input bit r, input logic [31:0] id, input logic [31:0] ex,
                      input bit br, input bit req, input bit rdy);
    logic [6:0] exp_vec;
    @(negedge clk);
    rst = r; id_instr = id; ex_instr = ex;
    branch_taken = br; mem_req = req; mem_ready = rdy;
    #1;
    exp_vec = model_outs(r, id, ex, br, req, rdy);
    s_vec = {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
             ifid_flush, idex_flush};
    chk("outputs", 32'(s_vec), 32'(exp_vec));
    chk("stall_cycles", stall_cycles, m_stall);
    chk("mem_error", 32'(mem_error), 32'(m_err));
    @(posedge clk);
    if (r) begin
      m_waiting = 0; m_wait_len = 0; m_err = 0; m_stall = '0;
    end else begin
      if (!exp_vec[6] && m_stall != 32'hFFFFFFFF) m_stall = m_stall + 32'd1;
      if (m_waiting) begin
        if (rdy) begin
          m_waiting = 0; m_wait_len = 0;
        end else begin
          m_wait_len++;
          if (m_wait_len >= int'(TIMEOUT)) m_err = 1;
        end
      end else if (req && !rdy) begin
        m_waiting = 1;
      end
    end
    #1;
    a_stall = stall_cycles;
    a_err   = mem_error;
  endtask

  function automatic logic [31:0] rnd_instr(input bit bias_load);
    logic [6:0] ops [9];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if (bias_load && $urandom_range(0, 1) == 1) w[6:0] = 7'h03;
    else w[6:0] = ops[$urandom_range(0, 8)];
    return w;
  endfunction

  initial begin
    rst = 1'b1; id_instr = I_NOP; ex_instr = I_NOP;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    m_waiting = 0; m_wait_len = 0; m_err = 0; m_stall = '0;

    // Reset fills with NOP.
    step(1, I_NOP, I_NOP, 0, 0, 0);
    chk("lit_reset_outs", 32'(s_vec), 32'h7F);
    step(1, I_NOP, I_NOP, 0, 0, 0);
    chk("lit_reset_stall", a_stall, 32'd0);
    chk("lit_reset_err", 32'(a_err), 32'd0);

    // Load to x0, then load with non-using LUI: no stall.
    step(0, I_ADD, I_LW_X0, 0, 0, 0);
    chk("lit_lw_x0", 32'(s_vec), 32'h7C);
    step(0, I_LUI_X5, I_LW_X5, 0, 0, 0);
    chk("lit_lui_no_use", 32'(s_vec), 32'h7C);
    chk("lit_no_stall_count", a_stall, 32'd0);

    // True load-use: one stall cycle, then NOP in EX releases it.
    step(0, I_ADD, I_LW_X5, 0, 0, 0);
    chk("lit_load_use", 32'(s_vec), 32'b0011101);
    chk("lit_load_use_count", a_stall, 32'd1);
    step(0, I_ADD, I_NOP, 0, 0, 0);
    chk("lit_after_bubble", 32'(s_vec), 32'h7C);

    // Branch overrides load-use.
    step(0, I_ADD, I_LW_X5, 1, 0, 0);
    chk("lit_branch_over_lu", 32'(s_vec), 32'h7F);
    chk("lit_branch_count", a_stall, 32'd1);

    // Three-cycle memory wait with branch held; ready cycle flushes.
    for (int i = 0; i < 3; i++) begin
      step(0, I_ADD, I_LW_X5, 1, 1, 0);
      chk("lit_freeze", 32'(s_vec), 32'h00);
    end
    chk("lit_freeze_count", a_stall, 32'd4);
    step(0, I_ADD, I_LW_X5, 1, 1, 1);
    chk("lit_ready_branch", 32'(s_vec), 32'h7F);
    chk("lit_ready_err", 32'(a_err), 32'd0);

    // Timeout: error appears after the fourth MEM_WAIT cycle and stays.
    for (int i = 0; i < 6; i++) begin
      step(0, I_NOP, I_NOP, 0, 1, 0);
      if (i == 3) chk("lit_err_not_yet", 32'(a_err), 32'd0);
      if (i == 4) chk("lit_err_set", 32'(a_err), 32'd1);
    end
    step(0, I_NOP, I_NOP, 0, 1, 1);
    chk("lit_err_sticky", 32'(a_err), 32'd1);
    chk("lit_timeout_count", a_stall, 32'd10);
    step(1, I_NOP, I_NOP, 0, 0, 0);
    chk("lit_err_cleared", 32'(a_err), 32'd0);
    chk("lit_stall_cleared", a_stall, 32'd0);

    // Reset in the middle of a wait.
    step(0, I_NOP, I_NOP, 0, 1, 0);
    step(0, I_NOP, I_NOP, 0, 1, 0);
    step(1, I_NOP, I_NOP, 0, 1, 0);
    chk("lit_rst_midwait", 32'(s_vec), 32'h7F);
    step(0, I_NOP, I_NOP, 0, 0, 0);
    chk("lit_after_rst_run", 32'(s_vec), 32'h7C);
    chk("lit_after_rst_count", a_stall, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit r, br, req, rdy;
      r   = ($urandom_range(0, 63) == 0);
      br  = ($urandom_range(0, 7) == 0);
      if (m_waiting) begin
        req = 1'b1;
        rdy = ($urandom_range(0, 3) == 0);
      end else begin
        req = ($urandom_range(0, 3) == 0);
        rdy = ($urandom_range(0, 1) == 0);
      end
      step(r, rnd_instr(0), rnd_instr(1), br, req, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
